mem_write_checker: RTL and testbench

- Synthesizable self-checking monitor for the MIPS core's data-memory write port; sits beside the top-level core and snoops memwrite/dataadr/writedata.
- Compares observed stores, in order, against a loadable table of up to DEPTH expected (address, data) pairs.
- Address window for scratch traffic is ignored; strict or lax mode; watchdog timeout; latched pass/fail verdict with failure capture.

---
 rtl/mem_write_checker_pkg.sv | 20 ++
 rtl/mwc_exp_table.sv | 33 +++
 rtl/mem_write_checker.sv | 131 +++++++++++++
 tb/tb_mem_write_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory store checker: FSM states, verdict codes, match modes.
// Pure declarations; no logic, no latency.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISMATCH = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_BADCNT   = 2'b11;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_LAX    = 1'b1;

endpackage

// File: rtl/mwc_exp_table.sv
// Expected (address, data) table: synchronous write, combinational read at rd_idx.
// Write lands on the next edge; read is same-cycle; no flow control.
module mwc_exp_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  // Contents deliberately survive reset so a run can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (we && (int'(wr_idx) < DEPTH)) begin
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_addr = addr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Snoops the core's store port and matches stores in order against the expected table.
// Verdict registered one edge after the deciding store; pure monitor, never stalls the core.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int IGN_LO  = 80,
  parameter int IGN_HI  = 80
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               mode,
  input  logic [$clog2(DEPTH+1)-1:0]         num_exp,
  input  logic                               ld_en,
  input  logic [((DEPTH>1)?$clog2(DEPTH):1)-1:0] ld_idx,
  input  logic [ADDR_W-1:0]                  ld_addr,
  input  logic [DATA_W-1:0]                  ld_data,
  input  logic                               memwrite,
  input  logic [ADDR_W-1:0]                  dataadr,
  input  logic [DATA_W-1:0]                  writedata,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [1:0]                         fail_code,
  output logic [$clog2(DEPTH+1)-1:0]         match_cnt,
  output logic [ADDR_W-1:0]                  fail_addr,
  output logic [DATA_W-1:0]                  fail_data
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [ADDR_W-1:0] IGN_LO_A = ADDR_W'(IGN_LO);
  localparam logic [ADDR_W-1:0] IGN_HI_A = ADDR_W'(IGN_HI);

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              ld_ok, in_win, hit, mism, tmo, last, bad_cnt;

  assign ld_ok = ld_en && (state != RUN);

  mwc_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_tbl (
    .clk     (clk),
    .we      (ld_ok),
    .wr_idx  (ld_idx),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_idx  (match_cnt[IDX_W-1:0]),
    .rd_addr (exp_addr),
    .rd_data (exp_data)
  );

  // Scratch-window stores are invisible, even if they would have matched.
  assign in_win  = (dataadr >= IGN_LO_A) && (dataadr <= IGN_HI_A);
  assign hit     = memwrite && !in_win && (dataadr == exp_addr) && (writedata == exp_data);
  assign mism    = memwrite && !in_win && !hit && (mode == MODE_STRICT);
  assign tmo     = (timer == TMR_W'(TIMEOUT - 1));
  assign last    = ((match_cnt + CNT_W'(1)) == num_exp);
  assign bad_cnt = (num_exp == '0) || (num_exp > CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (hit) begin
          if (last) state_nxt = PASS;
        end else if (mism || tmo) begin
          state_nxt = FAIL;
        end
      end
      default: begin
        if (start) state_nxt = bad_cnt ? FAIL : RUN;
      end
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == PASS) || (state == FAIL);
    pass = (state == PASS);
  end

  // Match beats timeout; a mismatch is reported with the offending store, a timeout with zeros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      match_cnt <= '0;
      timer     <= '0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state != RUN) begin
      if (start) begin
        match_cnt <= '0;
        timer     <= '0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_code <= bad_cnt ? FC_BADCNT : FC_NONE;
      end
    end else if (hit) begin
      match_cnt <= match_cnt + CNT_W'(1);
      timer     <= '0;
    end else if (mism) begin
      fail_code <= FC_MISMATCH;
      fail_addr <= dataadr;
      fail_data <= writedata;
    end else if (tmo) begin
      fail_code <= FC_TIMEOUT;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized runs scored against
// a cycle-counting reference model of the in-order store matching rules.
module tb_mem_write_checker;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  num_exp = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [3:0]  match_cnt;
  logic [31:0] fail_addr, fail_data;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGN_LO(80), .IGN_HI(80)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_exp(num_exp),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_data(ld_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] mt_addr [DEPTH];
  logic [31:0] mt_data [DEPTH];
  bit          ev_vld [$];
  logic [31:0] ev_addr [$];
  logic [31:0] ev_data [$];

  int          m_cyc, m_cnt;
  logic        m_pass;
  logic [1:0]  m_code;
  logic [31:0] m_fa, m_fd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_idx = 3'(idx); ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    mt_addr[idx] = a;
    mt_data[idx] = d;
  endtask

  task automatic add_ev(input bit v, input logic [31:0] a, input logic [31:0] d);
    ev_vld.push_back(v); ev_addr.push_back(a); ev_data.push_back(d);
  endtask

  task automatic clr_ev();
    ev_vld.delete(); ev_addr.delete(); ev_data.delete();
  endtask

  // Pulses start, then plays one queued event per cycle; dcyc = edges after the start edge
  // at which done was first seen (0 = on the start edge itself, -1 = never within budget).
  task automatic do_run(input int ne, input logic md, input int budget, output int dcyc);
    num_exp = 4'(ne); mode = md; start = 1'b1;
    tick();
    start = 1'b0;
    dcyc = -1;
    if (done) dcyc = 0;
    else begin
      for (int k = 1; k <= budget; k++) begin
        if (k - 1 < ev_vld.size()) begin
          memwrite = ev_vld[k-1]; dataadr = ev_addr[k-1]; writedata = ev_data[k-1];
        end else begin
          memwrite = 1'b0; dataadr = '0; writedata = '0;
        end
        tick();
        if (done) begin dcyc = k; break; end
      end
    end
    memwrite = 1'b0;
  endtask

  // Reference: walk the store stream, tracking entries matched and cycles since the last match.
  task automatic model(input int ne, input logic md, input int budget);
    int matched;
    int since;
    bit v;
    logic [31:0] a, d;
    bit ign;
    matched = 0; since = 0;
    m_cyc = -1; m_pass = 1'b0; m_code = 2'b00; m_cnt = 0; m_fa = '0; m_fd = '0;
    if (ne == 0 || ne > DEPTH) begin m_cyc = 0; m_code = 2'b11; return; end
    for (int k = 0; k < budget; k++) begin
      v = (k < ev_vld.size()) ? ev_vld[k] : 1'b0;
      a = (k < ev_vld.size()) ? ev_addr[k] : 32'd0;
      d = (k < ev_vld.size()) ? ev_data[k] : 32'd0;
      ign = v && (a == 32'd80);
      if (v && !ign && a == mt_addr[matched] && d == mt_data[matched]) begin
        matched++; since = 0; m_cnt = matched;
        if (matched == ne) begin m_cyc = k + 1; m_pass = 1'b1; return; end
      end else if (v && !ign && md == 1'b0) begin
        m_cyc = k + 1; m_code = 2'b01; m_fa = a; m_fd = d; return;
      end else begin
        since++;
        if (since == TIMEOUT) begin m_cyc = k + 1; m_code = 2'b10; return; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", done); end
    n_run++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0b exp 0", pass); end
    n_run++; if (fail_code !== 2'b00) begin n_fail++; $display("FAIL reset_code got %0b exp 00", fail_code); end
    n_run++; if (match_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", match_cnt); end
    n_run++; if (fail_addr !== 32'd0 || fail_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_capture got %0d/%0d exp 0/0", fail_addr, fail_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ignore_then_match();
    int dc;
    load(0, 32'd84, 32'd7);
    clr_ev(); add_ev(1, 32'd80, 32'd5); add_ev(1, 32'd84, 32'd7);
    do_run(1, 1'b0, 20, dc);
    n_run++; if (dc !== 2) begin n_fail++; $display("FAIL ign_cycle got %0d exp 2", dc); end
    n_run++; if (pass !== 1'b1) begin n_fail++; $display("FAIL ign_pass got %0b exp 1", pass); end
    n_run++; if (match_cnt !== 4'd1) begin n_fail++; $display("FAIL ign_cnt got %0d exp 1", match_cnt); end
    n_run++; if (fail_code !== 2'b00) begin n_fail++; $display("FAIL ign_code got %0b exp 00", fail_code); end
  endtask

  task automatic test_strict_mismatch();
    int dc;
    clr_ev(); add_ev(1, 32'd88, 32'd3);
    do_run(1, 1'b0, 20, dc);
    n_run++; if (dc !== 1) begin n_fail++; $display("FAIL mism_cycle got %0d exp 1", dc); end
    n_run++; if (pass !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mism_flags got pass=%0b busy=%0b exp 0/0", pass, busy); end
    n_run++; if (fail_code !== 2'b01) begin n_fail++; $display("FAIL mism_code got %0b exp 01", fail_code); end
    n_run++; if (fail_addr !== 32'd88 || fail_data !== 32'd3) begin
      n_fail++; $display("FAIL mism_capture got %0d/%0d exp 88/3", fail_addr, fail_data); end
  endtask

  task automatic test_lax();
    int dc;
    load(0, 32'd84, 32'd7); load(1, 32'd88, 32'd1); load(2, 32'd92, 32'd2);
    clr_ev();
    add_ev(1, 32'd84, 32'd7); add_ev(1, 32'd100, 32'd9); add_ev(1, 32'd80, 32'd0);
    add_ev(1, 32'd88, 32'd1); add_ev(1, 32'd96, 32'd4); add_ev(1, 32'd92, 32'd2);
    do_run(3, 1'b1, 30, dc);
    n_run++; if (dc !== 6) begin n_fail++; $display("FAIL lax_cycle got %0d exp 6", dc); end
    n_run++; if (pass !== 1'b1) begin n_fail++; $display("FAIL lax_pass got %0b exp 1", pass); end
    n_run++; if (match_cnt !== 4'd3) begin n_fail++; $display("FAIL lax_cnt got %0d exp 3", match_cnt); end
  endtask

  task automatic test_timeout();
    int dc;
    load(0, 32'd84, 32'd7);
    clr_ev();
    do_run(1, 1'b0, 30, dc);
    n_run++; if (dc !== 16) begin n_fail++; $display("FAIL tmo_cycle got %0d exp 16", dc); end
    n_run++; if (fail_code !== 2'b10) begin n_fail++; $display("FAIL tmo_code got %0b exp 10", fail_code); end
    n_run++; if (fail_addr !== 32'd0 || fail_data !== 32'd0) begin
      n_fail++; $display("FAIL tmo_capture got %0d/%0d exp 0/0", fail_addr, fail_data); end
    clr_ev();
    for (int i = 0; i < 15; i++) add_ev(0, 32'd0, 32'd0);
    add_ev(1, 32'd84, 32'd7);
    do_run(1, 1'b0, 30, dc);
    n_run++; if (dc !== 16) begin n_fail++; $display("FAIL tmo_edge_cycle got %0d exp 16", dc); end
    n_run++; if (pass !== 1'b1 || fail_code !== 2'b00) begin
      n_fail++; $display("FAIL tmo_edge_pass got pass=%0b code=%0b exp 1/00", pass, fail_code); end
  endtask

  task automatic test_bad_cnt();
    int dc;
    clr_ev();
    do_run(0, 1'b0, 5, dc);
    n_run++; if (dc !== 0 || fail_code !== 2'b11 || pass !== 1'b0) begin
      n_fail++; $display("FAIL badcnt0 got cyc=%0d code=%0b pass=%0b exp 0/11/0", dc, fail_code, pass); end
    do_run(DEPTH + 1, 1'b0, 5, dc);
    n_run++; if (dc !== 0 || fail_code !== 2'b11 || pass !== 1'b0) begin
      n_fail++; $display("FAIL badcnt9 got cyc=%0d code=%0b pass=%0b exp 0/11/0", dc, fail_code, pass); end
  endtask

  task automatic test_load_in_run();
    load(0, 32'd84, 32'd7);
    num_exp = 4'd1; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ld_en = 1'b1; ld_idx = 3'd0; ld_addr = 32'd200; ld_data = 32'd200;
    tick();
    ld_en = 1'b0;
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
    tick();
    memwrite = 1'b0;
    n_run++; if (pass !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL load_in_run got pass=%0b done=%0b exp 1/1", pass, done); end
  endtask

  task automatic test_reset_mid_run();
    int dc;
    load(0, 32'd84, 32'd7); load(1, 32'd88, 32'd1); load(2, 32'd92, 32'd2);
    num_exp = 4'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
    tick();
    memwrite = 1'b0;
    n_run++; if (match_cnt !== 4'd1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL midrun_pre got cnt=%0d busy=%0b exp 1/1", match_cnt, busy); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_run++; if ({busy, done, pass, fail_code, match_cnt} !== 9'd0 || fail_addr !== 32'd0 || fail_data !== 32'd0) begin
      n_fail++; $display("FAIL midrun_reset got busy=%0b done=%0b pass=%0b code=%0b cnt=%0d exp all 0",
                         busy, done, pass, fail_code, match_cnt); end
    clr_ev();
    add_ev(1, 32'd84, 32'd7); add_ev(1, 32'd88, 32'd1); add_ev(1, 32'd92, 32'd2);
    do_run(3, 1'b0, 30, dc);
    n_run++; if (dc !== 3 || pass !== 1'b1 || match_cnt !== 4'd3) begin
      n_fail++; $display("FAIL midrun_restart got cyc=%0d pass=%0b cnt=%0d exp 3/1/3", dc, pass, match_cnt); end
  endtask

  task automatic test_random();
    int dc, ne, nev, ptr, r, budget;
    logic md;
    logic [31:0] a;
    for (int it = 0; it < 30; it++) begin
      ne = $urandom_range(1, DEPTH);
      md = 1'($urandom_range(0, 1));
      for (int i = 0; i < ne; i++) begin
        a = ($urandom_range(0, 9) == 0) ? 32'd80 : 32'(84 + 4 * $urandom_range(0, 3));
        load(i, a, 32'($urandom_range(0, 3)));
      end
      clr_ev();
      if (it % 5 == 4) for (int i = 0; i < TIMEOUT + 1; i++) add_ev(0, 32'd0, 32'd0);
      nev = $urandom_range(ne, 3 * ne + 4);
      ptr = 0;
      for (int i = 0; i < nev; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4 && ptr < ne) begin add_ev(1, mt_addr[ptr], mt_data[ptr]); ptr++; end
        else if (r < 6) add_ev(0, 32'd0, 32'd0);
        else if (r < 7) add_ev(1, 32'd80, 32'($urandom_range(0, 9)));
        else add_ev(1, 32'(84 + 4 * $urandom_range(0, 4)), 32'($urandom_range(0, 3)));
      end
      budget = ev_vld.size() + TIMEOUT + 2;
      model(ne, md, budget);
      do_run(ne, md, budget, dc);
      n_run++; if (dc !== m_cyc) begin n_fail++; $display("FAIL rnd%0d_cycle got %0d exp %0d", it, dc, m_cyc); end
      n_run++; if (pass !== m_pass) begin n_fail++; $display("FAIL rnd%0d_pass got %0b exp %0b", it, pass, m_pass); end
      n_run++; if (fail_code !== m_code) begin n_fail++; $display("FAIL rnd%0d_code got %0b exp %0b", it, fail_code, m_code); end
      n_run++; if (match_cnt !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd%0d_cnt got %0d exp %0d", it, match_cnt, m_cnt); end
      n_run++; if (fail_addr !== m_fa || fail_data !== m_fd) begin
        n_fail++; $display("FAIL rnd%0d_capture got %0d/%0d exp %0d/%0d", it, fail_addr, fail_data, m_fa, m_fd); end
    end
  endtask

  initial begin
    test_reset();
    test_ignore_then_match();
    test_strict_mismatch();
    test_lax();
    test_timeout();
    test_bad_cnt();
    test_load_in_run();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
